// File: rtl/config_shift_chain.sv
// Double-buffered serial configuration chain: bits shift into a shadow chain
// under valid/ready, then commit atomically to the per-tile active outputs.
module config_shift_chain #(
    parameter int WIDTH = 16,
    parameter int TILES = 4,
    localparam int N    = WIDTH * TILES,
    localparam int CW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          cfg_valid,
    input  logic          cfg_bit,
    output logic          cfg_ready,
    output logic          scan_out,
    output logic [N-1:0]  cfg_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] bit_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  shadow_q, shadow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          accept;
    logic [TILES-1:0][WIDTH-1:0] cfg_q;

    // Abort wins over a same-cycle accept, so the bit is never taken.
    assign accept = (state_q == S_SHIFT) && cfg_valid && !abort;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    shadow_d = {cfg_bit, shadow_q[N-1:1]};
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Active per-tile selects only move on the commit edge.
    for (genvar t = 0; t < TILES; t++) begin : g_tile
        always_ff @(posedge clk) begin
            if (reset)
                cfg_q[t] <= '0;
            else if (state_q == S_COMMIT)
                cfg_q[t] <= shadow_q[t*WIDTH +: WIDTH];
        end
    end

    assign cfg_out   = cfg_q;
    assign cfg_ready = (state_q == S_SHIFT);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign scan_out  = shadow_q[0];
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_config_shift_chain.sv
// Scoreboard bench for config_shift_chain: expected images and readback bits
// are queued at stimulus time and popped when the DUT commits or shifts.
module tb_config_shift_chain;

    localparam int N  = 64;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset, start, abort, cfg_valid, cfg_bit;
    logic          cfg_ready, scan_out, busy, done;
    logic [N-1:0]  cfg_out;
    logic [CW-1:0] bit_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [N-1:0] img_q[$];
    logic         rb_q[$];

    config_shift_chain #(.WIDTH(16), .TILES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_ready(cfg_ready),
        .scan_out(scan_out), .cfg_out(cfg_out), .busy(busy), .done(done),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode: 0 normal, 1 abort at abort_at accepts, 2 reset at abort_at accepts,
    // 3 reset while in COMMIT. Returns at the done cycle (or after the cancel).
    task automatic do_load(input logic [N-1:0] pat, input int stall_mod, input int mode,
                           input int abort_at, input logic readback, output int edges);
        logic [N-1:0] prev;
        int k, cyc;
        logic v;
        prev = cfg_out;
        img_q.push_back(pat);
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 0;
        chk("ready_after_start", {63'b0, cfg_ready}, 64'd1);
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        chk("count_after_start", {{(N-CW){1'b0}}, bit_count}, 64'd0);
        k = 0;
        cyc = 0;
        while (k < N && cyc < 1000) begin
            v = !(stall_mod != 0 && (cyc % stall_mod) == stall_mod - 1);
            cfg_valid = v;
            cfg_bit   = pat[k];
            if (mode == 1 && k == abort_at) abort = 1'b1;
            if (mode == 2 && k == abort_at) reset = 1'b1;
            if (readback && v && mode == 0) begin
                if (rb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL readback_queue: empty at bit %0d", k);
                end else
                    chk("scan_out_readback", {63'b0, scan_out}, {63'b0, rb_q.pop_front()});
            end
            step();
            edges++;
            cyc++;
            if (abort || reset) begin
                abort = 1'b0; reset = 1'b0; cfg_valid = 1'b0;
                void'(img_q.pop_back());
                chk("cancel_ready", {63'b0, cfg_ready}, 64'd0);
                chk("cancel_busy", {63'b0, busy}, 64'd0);
                chk("cancel_count", {{(N-CW){1'b0}}, bit_count}, 64'd0);
                chk("cancel_done", {63'b0, done}, 64'd0);
                chk("cancel_cfg_out", cfg_out, (mode == 2) ? 64'd0 : prev);
                if (mode == 2) chk("reset_scan_out", {63'b0, scan_out}, 64'd0);
                step();
                chk("cancel_no_done", {63'b0, done}, 64'd0);
                return;
            end
            if (v) k++;
            chk("bit_count", {{(N-CW){1'b0}}, bit_count}, 64'(k));
            chk("cfg_out_hold", cfg_out, prev);
            if (done !== 1'b0) chk("early_done", {63'b0, done}, 64'd0);
        end
        if (cyc >= 1000) begin
            n_cmp++; n_err++;
            $display("FAIL load_timeout: only %0d bits accepted", k);
        end
        cfg_valid = 1'b0;
        chk("commit_ready", {63'b0, cfg_ready}, 64'd0);
        chk("commit_busy", {63'b0, busy}, 64'd1);
        if (mode == 3) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            void'(img_q.pop_back());
            chk("rst_commit_cfg_out", cfg_out, 64'd0);
            chk("rst_commit_done", {63'b0, done}, 64'd0);
            chk("rst_commit_busy", {63'b0, busy}, 64'd0);
            chk("rst_commit_scan", {63'b0, scan_out}, 64'd0);
            step();
            chk("rst_commit_no_done", {63'b0, done}, 64'd0);
            return;
        end
        step();
        edges++;
        chk("done_pulse", {63'b0, done}, 64'd1);
        chk("busy_at_done", {63'b0, busy}, 64'd0);
        chk("count_at_done", {{(N-CW){1'b0}}, bit_count}, 64'd0);
        chk("cfg_out_commit", cfg_out, img_q.pop_front());
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_cfg_out", cfg_out, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_ready", {63'b0, cfg_ready}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            cfg_valid = i[0];
            cfg_bit   = ~i[1];
            abort     = i[2];
            step();
        end
        cfg_valid = 1'b0; abort = 1'b0;
        chk("idle_cfg_out", cfg_out, 64'd0);
        chk("idle_scan_out", {63'b0, scan_out}, 64'd0);
        chk("idle_busy", {63'b0, busy}, 64'd0);
    endtask

    task automatic test_full_load();
        int e;
        do_load(64'hDEADBEEF_0123ABCD, 0, 0, 0, 1'b0, e);
        chk("done_latency", 64'(e), 64'd65);
        chk("tile1_field", {48'b0, cfg_out[31:16]}, 64'h0123);
        step();
        chk("done_single", {63'b0, done}, 64'd0);
    endtask

    task automatic test_stalled();
        int e;
        reset = 1'b1; step(); reset = 1'b0;
        do_load(64'hDEADBEEF_0123ABCD, 3, 0, 0, 1'b0, e);
        chk("stall_latency_longer", 64'(e > 65), 64'd1);
        step();
        chk("stall_done_single", {63'b0, done}, 64'd0);
    endtask

    task automatic test_readback();
        int e;
        logic [N-1:0] a;
        a = 64'hFFFF0000_AAAA5555;
        do_load(a, 0, 0, 0, 1'b0, e);
        step();
        for (int i = 0; i < N; i++) rb_q.push_back(a[i]);
        do_load(64'd0, 0, 0, 0, 1'b1, e);
        chk("readback_drained", 64'(rb_q.size()), 64'd0);
        step();
    endtask

    task automatic test_abort();
        int e;
        logic [N-1:0] prev;
        prev = 64'h0BAD_F00D_CAFE_1111;
        do_load(prev, 0, 0, 0, 1'b0, e);
        step();
        do_load(64'h12345678_9ABCDEF0, 0, 1, 20, 1'b0, e);
        chk("abort_keeps_cfg", cfg_out, prev);
        do_load(64'h5A5A_0F0F_3C3C_9999, 2, 0, 0, 1'b0, e);
        step();
    endtask

    task automatic test_reset_mid();
        int e;
        do_load(64'h1111_2222_3333_4444, 0, 2, 40, 1'b0, e);
        chk("rst_mid_cfg_out", cfg_out, 64'd0);
        do_load(64'h7777_8888_9999_AAAA, 0, 3, 0, 1'b0, e);
    endtask

    task automatic test_back_to_back();
        int e;
        do_load(64'hA5A5_A5A5_5A5A_5A5A, 0, 0, 0, 1'b0, e);
        do_load(64'hC3C3_3C3C_0000_FFFF, 0, 0, 0, 1'b0, e);
        chk("b2b_latency", 64'(e), 64'd65);
        step();
        chk("b2b_done_single", {63'b0, done}, 64'd0);
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_stalled();
        test_readback();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
